// File: rtl/pmem_burst_responder.sv
// Cache-line to memory-burst bridge: one line read/write becomes BEATS ascending beat transfers.
// Latency: request seen in IDLE -> burst starts next cycle; line_resp the cycle after the last acknowledged beat.
// Backpressure: each beat is held until burst_resp; cache request is ignored while a transaction is in flight.
module pmem_burst_responder #(
    parameter int LINE_W   = 256,
    parameter int BEAT_W   = 64,
    parameter int OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic              line_resp,
    output logic [LINE_W-1:0] line_rdata,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_addr,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp,
    output logic [31:0]       num_reads,
    output logic [31:0]       num_writes
);

    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_BURST = 2'd1;
    localparam logic [1:0] S_WR_BURST = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

    logic [1:0]         state;
    logic [BEAT_CW-1:0] beat;
    logic [31:0]        addr_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rdata_q;
    logic               is_write_q;
    logic [31:0]        rd_cnt;
    logic [31:0]        wr_cnt;
    logic               last_beat;

    assign last_beat = (beat == BEAT_CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            beat       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    beat <= '0;
                    // Write wins when both requests are raised together.
                    if (line_write) begin
                        addr_q     <= line_addr & ADDR_MASK;
                        wdata_q    <= line_wdata;
                        is_write_q <= 1'b1;
                        state      <= S_WR_BURST;
                    end else if (line_read) begin
                        addr_q     <= line_addr & ADDR_MASK;
                        is_write_q <= 1'b0;
                        state      <= S_RD_BURST;
                    end
                end
                S_RD_BURST: begin
                    if (burst_resp) begin
                        rdata_q[beat*BEAT_W +: BEAT_W] <= burst_rdata;
                        if (last_beat) begin
                            beat  <= '0;
                            state <= S_RESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_WR_BURST: begin
                    if (burst_resp) begin
                        if (last_beat) begin
                            beat  <= '0;
                            state <= S_RESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: begin
                    if (is_write_q) begin
                        wr_cnt <= wr_cnt + 32'd1;
                    end else begin
                        rd_cnt <= rd_cnt + 32'd1;
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        burst_read  = (state == S_RD_BURST);
        burst_write = (state == S_WR_BURST);
        line_resp   = (state == S_RESP);
        burst_addr  = '0;
        burst_wdata = '0;
        if (state == S_RD_BURST || state == S_WR_BURST) begin
            burst_addr = addr_q;
        end
        if (state == S_WR_BURST) begin
            burst_wdata = wdata_q[beat*BEAT_W +: BEAT_W];
        end
    end

    assign line_rdata = rdata_q;
    assign num_reads  = rd_cnt;
    assign num_writes = wr_cnt;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Scoreboarded bench for pmem_burst_responder: a memory model answers bursts,
// a negedge monitor checks beats, addresses and completed lines against queued expectations.
module tb_pmem_burst_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata;
    logic         line_resp;
    logic [255:0] line_rdata;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_addr;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata = 64'h0;
    logic         burst_resp = 1'b0;
    logic [31:0]  num_reads;
    logic [31:0]  num_writes;

    pmem_burst_responder #(.LINE_W(256), .BEAT_W(64), .OFFSET_W(5)) dut (
        .clk(clk), .rst(rst),
        .line_read(line_read), .line_write(line_write),
        .line_addr(line_addr), .line_wdata(line_wdata),
        .line_resp(line_resp), .line_rdata(line_rdata),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_addr(burst_addr), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp),
        .num_reads(num_reads), .num_writes(num_writes)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0]  mem_rd_q[$];
    logic [63:0]  exp_wq[$];
    logic [255:0] exp_rq[$];
    logic [255:0] exp_line_mon;
    logic [31:0]  exp_addr = 32'h0;
    logic [255:0] last_line = '0;
    int           exp_nr = 0;
    int           exp_nw = 0;
    int           mode = 0;   // 0: ack every cycle, 1: every other cycle, 3: ack always (even idle)
    bit           tog = 1'b0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: acknowledges beats and supplies read data from the queue.
    always @(posedge clk) begin
        #2;
        if (mode == 3 || ((burst_read || burst_write) && (mode == 0 || (mode == 1 && tog)))) begin
            burst_resp  = 1'b1;
            burst_rdata = (burst_read && mem_rd_q.size() > 0) ? mem_rd_q[0] : 64'h0;
        end else begin
            burst_resp  = 1'b0;
            burst_rdata = 64'h0;
        end
        tog = !tog;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (burst_read || burst_write) begin
                check_val("rd_wr_exclusive", burst_read && burst_write, 0);
                check_val("burst_addr", burst_addr, exp_addr);
            end
            if (burst_write) begin
                if (exp_wq.size() == 0) begin
                    check_val("wbeat_unexpected", burst_write, 0);
                end else begin
                    check_val("burst_wdata", burst_wdata, exp_wq[0]);
                    if (burst_resp) void'(exp_wq.pop_front());
                end
            end
            if (burst_read && burst_resp && mem_rd_q.size() > 0) void'(mem_rd_q.pop_front());
            if (line_resp) begin
                if (exp_rq.size() == 0) begin
                    check_val("resp_unexpected", line_resp, 0);
                end else begin
                    exp_line_mon = exp_rq.pop_front();
                    check_val("line_rdata", line_rdata, exp_line_mon);
                end
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [255:0] wd, input logic [255:0] rline);
        exp_addr = a & 32'hFFFF_FFE0;
        if (wr) begin
            for (int i = 0; i < 4; i++) exp_wq.push_back(wd[i*64 +: 64]);
            exp_rq.push_back(last_line);
            exp_nw++;
        end else begin
            for (int i = 0; i < 4; i++) mem_rd_q.push_back(rline[i*64 +: 64]);
            exp_rq.push_back(rline);
            last_line = rline;
            exp_nr++;
        end
        line_read  = rd;
        line_write = wr;
        line_addr  = a;
        line_wdata = wd;
    endtask

    task automatic wait_resp();
        int c = 0;
        while (!line_resp && c < 40) begin
            tick();
            c++;
        end
        check_val("resp_seen", line_resp, 1);
        line_read  = 1'b0;
        line_write = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_num_reads"}, num_reads, exp_nr);
        check_val({tag, "_num_writes"}, num_writes, exp_nw);
    endtask

    logic [255:0] l1, l3, l5, l6, wd1, wd2, wd3;

    initial begin
        l1  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        l3  = 256'hA0A0_0000_0000_0003_B1B1_0000_0000_0002_C2C2_0000_0000_0001_D3D3_0000_0000_0000;
        l5  = 256'h5555_0000_1111_2222_6666_0000_3333_4444_7777_0000_5555_6666_8888_0000_7777_8888;
        l6  = 256'h0606_0606_0606_0606_0505_0505_0505_0505_0404_0404_0404_0404_0303_0303_0303_0303;
        wd1 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        wd2 = 256'hCAFE_0000_0000_0004_CAFE_0000_0000_0003_CAFE_0000_0000_0002_CAFE_0000_0000_0001;
        wd3 = 256'h9999_8888_7777_6666_5555_4444_3333_2222_1111_0000_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA;
        rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_addr = '0; line_wdata = '0;
        repeat (2) tick();
        check_val("rst_line_resp", line_resp, 0);
        check_val("rst_burst_read", burst_read, 0);
        check_val("rst_burst_write", burst_write, 0);
        check_val("rst_burst_addr", burst_addr, 0);
        check_val("rst_burst_wdata", burst_wdata, 0);
        check_val("rst_line_rdata", line_rdata, 0);
        check_counts("rst");
        rst = 1'b0;
        tick();

        // Minimum-latency read
        mode = 0;
        issue(1, 0, 32'h0000_1234, '0, l1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_val("lat_burst_read", burst_read, 1);
            check_val("lat_burst_addr", burst_addr, 32'h0000_1220);
            check_val("lat_no_resp", line_resp, 0);
        end
        tick();
        check_val("lat_resp_cycle5", line_resp, 1);
        check_val("lat_read_off", burst_read, 0);
        line_read = 1'b0;
        tick();
        check_val("resp_one_cycle", line_resp, 0);
        check_val("idle_burst_addr", burst_addr, 0);
        check_val("read1_line", line_rdata, l1);
        check_counts("read1");

        // Write with slow acknowledges; inputs disturbed mid-burst
        mode = 1;
        issue(0, 1, 32'h0000_0040, wd1, '0);
        tick(); tick();
        line_addr  = 32'hDEAD_0000;
        line_wdata = ~wd1;
        wait_resp();
        tick();
        check_val("write1_beats_left", exp_wq.size(), 0);
        check_val("write1_line_held", line_rdata, l1);
        check_counts("write1");

        // Simultaneous read and write -> write only
        mode = 0;
        issue(1, 1, 32'h0000_0080, wd2, '0);
        tick();
        check_val("both_no_read", burst_read, 0);
        check_val("both_write", burst_write, 1);
        wait_resp();
        tick();
        check_counts("both");

        // Read request dropped after beat 1
        issue(1, 0, 32'h0000_0100, '0, l3);
        repeat (3) tick();
        line_read = 1'b0;
        wait_resp();
        tick();
        check_val("drop_line", line_rdata, l3);
        check_counts("drop");

        // Stray acknowledges while idle are ignored
        mode = 3;
        repeat (3) begin
            tick();
            check_val("stray_no_read", burst_read, 0);
            check_val("stray_no_resp", line_resp, 0);
        end
        check_counts("stray");
        mode = 0;
        tick();

        // Reset in the middle of a read
        issue(1, 0, 32'h0000_0200, '0, ~l3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_val("mid_rst_read_off", burst_read, 0);
        check_val("mid_rst_no_resp", line_resp, 0);
        check_val("mid_rst_line", line_rdata, 0);
        rst = 1'b0; line_read = 1'b0;
        mem_rd_q.delete(); exp_wq.delete(); exp_rq.delete();
        exp_nr = 0; exp_nw = 0; last_line = '0;
        check_counts("mid_rst");
        tick();
        issue(1, 0, 32'h0000_0300, '0, l5);
        wait_resp();
        tick();
        check_val("post_rst_line", line_rdata, l5);
        check_counts("post_rst");

        // Back-to-back read then write
        issue(1, 0, 32'h0000_0400, '0, l6);
        wait_resp();
        issue(0, 1, 32'h0000_0480, wd3, '0);
        tick();
        check_val("b2b_idle_gap", burst_write, 0);
        tick();
        check_val("b2b_write_start", burst_write, 1);
        wait_resp();
        tick();
        check_val("b2b_beats_left", exp_wq.size(), 0);
        check_val("b2b_pending_resp", exp_rq.size(), 0);
        check_counts("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
